// File: rtl/fft_power_averager.sv
// Per-bin power averager behind the fft core: accumulates re^2+im^2 over 2^AVG_LOG2 frames, then drains bins 0..N-1.
// Optional macro FFT_PWR_PEAK_EN adds peak_power/peak_bin tracking of the drained spectrum.
module fft_power_averager #(
  parameter  int BITS     = 14,
  parameter  int N        = 1024,
  parameter  int AVG_LOG2 = 2,
  localparam int PW       = 2*BITS+1,
  localparam int LN       = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [BITS-1:0] in_real,
  input  logic signed [BITS-1:0] in_imag,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [1:0]             in_error,
  output logic [PW-1:0]          out_power,
  output logic [LN-1:0]          out_bin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   frame_drop,
`ifdef FFT_PWR_PEAK_EN
  output logic [PW-1:0]          peak_power,
  output logic [LN-1:0]          peak_bin,
`endif
  output logic                   frame_err
);

  localparam int AW = PW + AVG_LOG2;
  localparam int W2 = 2*BITS;
  localparam int NF = 1 << AVG_LOG2;
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;
  typedef struct packed {
    logic [LN-1:0] bin;
    logic          first;
  } tag_t;

  state_t               state, state_d;
  logic [LN-1:0]        bin_cnt, bin_d;
  logic [FW-1:0]        frm_cnt, frm_d;
  logic                 acc_beat, err_p, drop_p;
  tag_t                 beat_tag, s1_tag, s2_tag;
  logic [1:0]           vld_pipe;
  logic signed [W2-1:0] re_x, im_x, sq_re, sq_im;
  logic [PW-1:0]        pow;
  logic [AW-1:0]        mem [N];
  logic [AW-1:0]        rd_q;
  logic [LN-1:0]        dr_addr, rd_bin;
  logic                 dr_all, rv, issue, advance, eop_xfer, sop_ok, frame_bad;

  assign re_x      = W2'(in_real);
  assign im_x      = W2'(in_imag);
  assign advance   = !out_valid || out_ready;
  assign eop_xfer  = out_valid && out_ready && out_eop;
  assign sop_ok    = in_valid && in_sop && (in_error == 2'd0);
  assign frame_bad = (in_eop && bin_cnt != LN'(N-1)) || (in_sop && bin_cnt != '0) ||
                     (in_error != 2'd0);
  assign issue     = (state == DRAIN) && !dr_all && advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d  = state;
    bin_d    = bin_cnt;
    frm_d    = frm_cnt;
    acc_beat = 1'b0;
    beat_tag = '{bin: '0, first: 1'b1};
    err_p    = 1'b0;
    drop_p   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sop_ok) begin
          state_d  = ACCUM;
          acc_beat = 1'b1;
          bin_d    = LN'(1);
          frm_d    = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (frame_bad) begin
            err_p   = 1'b1;
            frm_d   = '0;
            bin_d   = '0;
            state_d = IDLE;
            // A clean sop on the faulty beat opens a fresh set right away.
            if (sop_ok) begin
              state_d  = ACCUM;
              acc_beat = 1'b1;
              bin_d    = LN'(1);
            end
          end else begin
            acc_beat = 1'b1;
            beat_tag = '{bin: bin_cnt, first: (frm_cnt == '0)};
            bin_d    = bin_cnt + LN'(1);
            if (in_eop) begin
              if (frm_cnt == FW'(NF-1)) begin
                state_d = FLUSH;
                frm_d   = '0;
              end else begin
                frm_d = frm_cnt + FW'(1);
              end
            end
          end
        end
      end
      FLUSH: begin
        drop_p = in_valid && in_sop;
        // Last write lands on the edge that enters DRAIN; first read is one cycle later.
        if (!vld_pipe[0]) state_d = DRAIN;
      end
      DRAIN: begin
        if (eop_xfer) begin
          state_d = IDLE;
          if (sop_ok) begin
            state_d  = ACCUM;
            acc_beat = 1'b1;
            bin_d    = LN'(1);
            frm_d    = '0;
          end
        end else begin
          drop_p = in_valid && in_sop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt    <= '0;
      frm_cnt    <= '0;
      vld_pipe   <= '0;
      s1_tag     <= '0;
      s2_tag     <= '0;
      sq_re      <= '0;
      sq_im      <= '0;
      pow        <= '0;
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      bin_cnt    <= bin_d;
      frm_cnt    <= frm_d;
      vld_pipe   <= {vld_pipe[0], acc_beat};
      s1_tag     <= beat_tag;
      s2_tag     <= s1_tag;
      sq_re      <= re_x * re_x;
      sq_im      <= im_x * im_x;
      pow        <= PW'(sq_re) + PW'(sq_im);
      frame_err  <= err_p;
      frame_drop <= drop_p;
    end
  end

  // Bin RAM: registered read shared by accumulate (stage 1 address) and drain prefetch.
  always_ff @(posedge clk) begin
    if (vld_pipe[1])
      mem[s2_tag.bin] <= s2_tag.first ? AW'(pow) : rd_q + AW'(pow);
    if (vld_pipe[0] || issue)
      rd_q <= mem[vld_pipe[0] ? s1_tag.bin : dr_addr];
  end

  // rd_q acts as the prefetch slot; it only reloads when the output slot advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dr_addr   <= '0;
      dr_all    <= 1'b0;
      rv        <= 1'b0;
      rd_bin    <= '0;
      out_valid <= 1'b0;
      out_power <= '0;
      out_bin   <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      if (state != DRAIN) begin
        dr_addr <= '0;
        dr_all  <= 1'b0;
      end else if (issue) begin
        dr_addr <= dr_addr + LN'(1);
        dr_all  <= (dr_addr == LN'(N-1));
      end
      if (issue) rd_bin <= dr_addr;
      if (advance) begin
        rv        <= issue;
        out_valid <= rv;
        out_power <= rv ? PW'(rd_q >> AVG_LOG2) : '0;
        out_bin   <= rv ? rd_bin : '0;
        out_sop   <= rv && (rd_bin == '0);
        out_eop   <= rv && (rd_bin == LN'(N-1));
      end
    end
  end

`ifdef FFT_PWR_PEAK_EN
  // The sop beat restarts the search, so the previous peak stays visible until the next drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_power <= '0;
      peak_bin   <= '0;
    end else if (out_valid && out_ready && (out_sop || out_power > peak_power)) begin
      peak_power <= out_power;
      peak_bin   <= out_bin;
    end
  end
`else
  // No peak tracking in this build.
`endif

endmodule

// File: doc/fft_power_averager.md
Name: fft_power_averager

Overview:
- Sits directly downstream of the fft core and consumes its output stream (real/imag, valid, sop, eop, error).
- Computes per-bin power re^2+im^2 and accumulates it over 2^AVG_LOG2 consecutive frames in an internal bin RAM.
- Streams the averaged spectrum out, bin 0..N-1, on a valid/ready interface to the display/readout logic.
- The fft core has no backpressure, so input frames arriving while the averaged spectrum is draining are dropped and flagged.

Parameters:
- BITS, 14, signed width of in_real/in_imag; matches the fft BITS.
- N, 1024, FFT points per frame; power of two, 16..4096.
- AVG_LOG2, 2, log2 of the number of frames averaged; range 0..4.
- Derived widths: PW=2*BITS+1 (power), AW=PW+AVG_LOG2 (accumulator), LN=log2(N).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_real  in  BITS  fft out_real, signed two's complement.
- in_imag  in  BITS  fft out_imag, signed.
- in_valid  in  1  fft out_valid.
- in_sop  in  1  fft out_sop; marks bin 0.
- in_eop  in  1  fft out_eop; marks bin N-1.
- in_error  in  2  fft out_error; nonzero with in_valid is a framing error.
- out_power  out  PW  averaged power, unsigned.
- out_bin  out  LN  bin index of out_power.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sop  out  1  beat is bin 0.
- out_eop  out  1  beat is bin N-1.
- frame_drop  out  1  one-cycle pulse when an input frame is discarded during DRAIN.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: all outputs 0; state IDLE; bin counter and frame counter 0. The RAM is not cleared; the first frame of each set overwrites it.
- Power pipeline: stage 1 registers re*re and im*im, signed 2*BITS each. Stage 2 sums them to PW bits, unsigned. Worst case (-2^(BITS-1))^2*2 = 2^(2*BITS-1) fits with no overflow.
- Accumulate: read-modify-write per valid beat.
  - Read address = input bin counter, registered, one-cycle RAM read, aligned with stage 2.
  - On the first frame of a set the power is written directly. On later frames acc+power is written.
  - One beat per cycle to distinct consecutive addresses, so no RAW hazard.
  - Write completes 3 cycles after the input beat.
- States:
  - IDLE: wait for in_valid&&in_sop, then go to ACCUM with bin=0 and frame=0. A beat without sop is ignored.
  - ACCUM: each valid beat increments bin. in_eop with bin==N-1 increments frame; when frame reaches 2^AVG_LOG2-1, go to DRAIN after the final write retires (pipeline flush, 3 cycles).
  - DRAIN: read RAM bins 0..N-1 in order. out_power = acc>>AVG_LOG2 (truncate). out_bin = index; out_sop at bin 0; out_eop at bin N-1.
  - Handshake: a beat transfers when out_valid&&out_ready. out_power/out_bin/out_sop/out_eop hold stable while out_valid&&!out_ready. Prefetch keeps 1 beat/cycle when out_ready is held high.
  - After the eop beat transfers, go to IDLE.
- Latency: first out_valid is 5 cycles after the last input eop beat of the set.
- Framing error conditions in ACCUM:
  - in_eop at bin!=N-1;
  - in_sop at bin!=0;
  - in_error!=0 on a valid beat.
  - Response: frame_err pulses 1 cycle, the set is discarded (frame=0), and the block returns to IDLE. If that beat is itself an sop, it restarts ACCUM immediately.
- DRAIN input: any in_valid&&in_sop pulses frame_drop; that frame is ignored. The next set starts on the first sop after returning to IDLE.
- Simultaneous: the eop-beat transfer and an input sop in the same cycle. The block goes to IDLE and that sop starts a new set (no drop).
- Reset asserted mid-operation: immediate return to reset values; a partial drain is abandoned with no out_eop.

Optional Feature:
- Macro FFT_PWR_PEAK_EN.
- Defined: adds outputs peak_power[PW-1:0] and peak_bin[LN-1:0], updated during DRAIN. They hold the largest averaged bin (lowest index wins ties) and are valid from the cycle after the out_eop transfer until the next DRAIN starts. Both reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random inputs -> all outputs 0 and no out_valid until a full 4-frame set completes.
- Tone, N=16, AVG_LOG2=2: 4 frames with bin3 re=100, im=-50, all others 0 -> drain gives bin3=12500, others 0; out_sop on bin0, out_eop on bin15.
- Averaging: bin0 re=10,20,30,40 (im=0) across 4 frames -> out_power(bin0)=(100+400+900+1600)>>2=750. Full scale re=im=-8192 -> 134217728.
- Backpressure: out_ready=0 for 5 cycles while bin7 is presented -> bin7 held stable, then bins 7..15 each delivered exactly once.
- Framing error: in_eop at bin9 of frame 2 -> frame_err is one pulse, no output. The next 4 clean frames drain correct values.
- Drop/reset: a sop during DRAIN gives frame_drop=1 for one cycle and that frame is ignored. reset_n=0 at drain bin5 -> outputs 0 at once and no out_eop.
